kernel_sequencer: RTL and testbench

//  Synthesisable successor to the frame-build op interpreter: fetches a 6502-subset kernel from a byte ROM.

---
 rtl/kseq_pkg.sv | 46 ++++
 rtl/kseq_if.sv | 28 ++
 rtl/kseq_decoder.sv | 50 +++++
 rtl/kernel_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_kernel_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kseq_pkg.sv
// kseq_pkg: opcodes, opcode classes and FSM encoding for kernel_sequencer.
// STA/STX/STY absolute are decoded only when KSEQ_ABS_STORE_EN is defined.
package kseq_pkg;

    localparam logic [7:0] OP_LDA     = 8'hA9;
    localparam logic [7:0] OP_LDX     = 8'hA2;
    localparam logic [7:0] OP_LDY     = 8'hA0;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_STA     = 8'h85;
    localparam logic [7:0] OP_STX     = 8'h86;
    localparam logic [7:0] OP_STY     = 8'h84;
    localparam logic [7:0] OP_JMP     = 8'h4C;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_STX_ABS = 8'h8E;
    localparam logic [7:0] OP_STY_ABS = 8'h8C;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT,
        ST_WAIT2,
        ST_EXEC,
        ST_HALT_DONE,
        ST_HALT_ERR
    } state_e;

    typedef enum logic [2:0] {
        CLS_IMM,
        CLS_ZP_STORE,
        CLS_ABS_STORE,
        CLS_JMP,
        CLS_NOP,
        CLS_BAD
    } op_class_e;

    typedef enum logic [1:0] {
        REG_A,
        REG_X,
        REG_Y
    } reg_sel_e;

    // Stores own the bus on their last cycle, so RDY cannot hold them.
    function automatic logic is_store(input op_class_e c);
        return (c == CLS_ZP_STORE) || (c == CLS_ABS_STORE);
    endfunction

endpackage

// File: rtl/kseq_if.sv
// kseq_if: kernel ROM read port and TIA register-write bus.
// master = sequencer, slave = ROM/TIA side.
interface kseq_if #(
    parameter int ADDR_W  = 14,
    parameter int TIA_A_W = 6
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [7:0]         rom_data;
    logic [TIA_A_W-1:0] tia_a;
    logic [7:0]         tia_d;
    logic               tia_we;

    modport master (
        output rom_addr,
        output tia_a,
        output tia_d,
        output tia_we,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  tia_a,
        input  tia_d,
        input  tia_we,
        output rom_data
    );
endinterface

// File: rtl/kseq_decoder.sv
// kseq_decoder: opcode -> {class, register select}.
// Absolute stores decode only with KSEQ_ABS_STORE_EN; otherwise CLS_BAD.
module kseq_decoder
    import kseq_pkg::*;
(
    input  logic [7:0] op,
    output op_class_e  cls,
    output reg_sel_e   sel
);

    always_comb begin
        cls = CLS_BAD;
        sel = REG_A;
        case (op)
            OP_LDA: cls = CLS_IMM;
            OP_LDX: begin
                cls = CLS_IMM;
                sel = REG_X;
            end
            OP_LDY: begin
                cls = CLS_IMM;
                sel = REG_Y;
            end
            OP_NOP: cls = CLS_NOP;
            OP_JMP: cls = CLS_JMP;
            OP_STA: cls = CLS_ZP_STORE;
            OP_STX: begin
                cls = CLS_ZP_STORE;
                sel = REG_X;
            end
            OP_STY: begin
                cls = CLS_ZP_STORE;
                sel = REG_Y;
            end
`ifdef KSEQ_ABS_STORE_EN
            OP_STA_ABS: cls = CLS_ABS_STORE;
            OP_STX_ABS: begin
                cls = CLS_ABS_STORE;
                sel = REG_X;
            end
            OP_STY_ABS: begin
                cls = CLS_ABS_STORE;
                sel = REG_Y;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/kernel_sequencer.sv
// kernel_sequencer: 6502-subset kernel interpreter driving the TIA write bus.
// Optional KSEQ_ABS_STORE_EN adds 4-cycle absolute stores (8D/8E/8C).
module kernel_sequencer
    import kseq_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int BANK_W  = 10,
    parameter int TIA_A_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_tick,
    input  logic              rdy,
    input  logic [ADDR_W:0]   rom_size,
    kseq_if.master            bus,
    output logic [ADDR_W-1:0] pc,
    output logic              done,
    output logic              error,
    output logic [7:0]        error_op
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] BANK_RND = ADDR_W'((1 << BANK_W) - 1);
    localparam logic [ADDR_W-1:0] BANK_MASK = ~BANK_RND;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [ADDR_W:0]    rom_size_q;
    logic [TIA_A_W-1:0] tia_a_q, tia_a_d;
    logic [7:0]         tia_d_q, tia_d_d;
    logic               tia_we_q, tia_we_d;
    logic [7:0]         a_q, a_d, x_q, x_d, y_q, y_d;
    op_class_e          cls_q, cls_d;
    reg_sel_e           sel_q, sel_d;
    logic [TIA_A_W-1:0] lo_q, lo_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [7:0]         error_op_q, error_op_d;

    op_class_e dec_cls;
    reg_sel_e  dec_sel;
    logic      adv;
    logic      exec_tick;

    kseq_decoder u_dec (
        .op  (bus.rom_data),
        .cls (dec_cls),
        .sel (dec_sel)
    );

    assign adv       = cpu_tick & rdy;
    assign exec_tick = cpu_tick & (rdy | is_store(cls_q));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rom_addr_d = pc_q;
        tia_a_d    = tia_a_q;
        tia_d_d    = tia_d_q;
        tia_we_d   = 1'b0;
        a_d        = a_q;
        x_d        = x_q;
        y_d        = y_q;
        cls_d      = cls_q;
        sel_d      = sel_q;
        lo_d       = lo_q;
        done_d     = done_q;
        error_d    = error_q;
        error_op_d = error_op_q;
        unique case (state_q)
            ST_FETCH: begin
                // Only reachable with pc past the image at reset release.
                if ({1'b0, pc_q} >= rom_size_q) begin
                    state_d = ST_HALT_DONE;
                    done_d  = 1'b1;
                end else if (adv) begin
                    pc_d  = pc_q + PC_ONE;
                    cls_d = dec_cls;
                    sel_d = dec_sel;
                    case (dec_cls)
                        CLS_IMM, CLS_NOP: state_d = ST_EXEC;
                        CLS_BAD: begin
                            state_d    = ST_HALT_ERR;
                            error_d    = 1'b1;
                            error_op_d = bus.rom_data;
                        end
                        default: state_d = ST_WAIT;
                    endcase
                end
            end
            ST_WAIT: begin
                if (adv) begin
                    if (cls_q == CLS_ABS_STORE) state_d = ST_WAIT2;
                    else state_d = ST_EXEC;
                end
            end
            ST_WAIT2: begin
                if (adv) begin
                    lo_d    = bus.rom_data[TIA_A_W-1:0];
                    pc_d    = pc_q + PC_ONE;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_tick) begin
                    case (cls_q)
                        CLS_IMM: begin
                            pc_d = pc_q + PC_ONE;
                            case (sel_q)
                                REG_X:   x_d = bus.rom_data;
                                REG_Y:   y_d = bus.rom_data;
                                default: a_d = bus.rom_data;
                            endcase
                        end
                        CLS_ZP_STORE: begin
                            pc_d    = pc_q + PC_ONE;
                            tia_a_d = bus.rom_data[TIA_A_W-1:0];
                        end
                        CLS_ABS_STORE: begin
                            pc_d    = pc_q + PC_ONE;
                            tia_a_d = lo_q;
                        end
                        CLS_JMP: pc_d = (pc_q + BANK_RND) & BANK_MASK;
                        default: ;
                    endcase
                    if (is_store(cls_q)) begin
                        tia_we_d = 1'b1;
                        tia_d_d  = (sel_q == REG_X) ? x_q :
                                   (sel_q == REG_Y) ? y_q : a_q;
                    end
                    if ({1'b0, pc_d} >= rom_size_q) begin
                        state_d = ST_HALT_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= '0;
            rom_addr_q <= '0;
            rom_size_q <= rom_size;
            tia_a_q    <= '0;
            tia_d_q    <= '0;
            tia_we_q   <= 1'b0;
            a_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cls_q      <= CLS_NOP;
            sel_q      <= REG_A;
            lo_q       <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            error_op_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rom_addr_q <= rom_addr_d;
            tia_a_q    <= tia_a_d;
            tia_d_q    <= tia_d_d;
            tia_we_q   <= tia_we_d;
            a_q        <= a_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cls_q      <= cls_d;
            sel_q      <= sel_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            error_q    <= error_d;
            error_op_q <= error_op_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.tia_a    = tia_a_q;
    assign bus.tia_d    = tia_d_q;
    assign bus.tia_we   = tia_we_q;
    assign pc           = pc_q;
    assign done         = done_q;
    assign error        = error_q;
    assign error_op     = error_op_q;

endmodule

// File: tb/tb_kernel_sequencer.sv
// tb_kernel_sequencer: instruction-level reference model vs kernel_sequencer,
// directed kernels plus random programs with random RDY.
module tb_kernel_sequencer;

    localparam int AW = 14;
    localparam int DEPTH = 1 << AW;
`ifdef KSEQ_ABS_STORE_EN
    localparam bit ABS_EN = 1'b1;
`else
    localparam bit ABS_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_tick = 1'b0;
    logic          rdy = 1'b1;
    logic [AW:0]   rom_size = '0;
    logic [AW-1:0] pc;
    logic          done;
    logic          error;
    logic [7:0]    error_op;
    logic [7:0]    rom [0:DEPTH-1];

    kseq_if #(.ADDR_W(AW), .TIA_A_W(6)) bus ();

    kernel_sequencer #(
        .ADDR_W  (AW),
        .BANK_W  (10),
        .TIA_A_W (6)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_tick (cpu_tick),
        .rdy      (rdy),
        .rom_size (rom_size),
        .bus      (bus),
        .pc       (pc),
        .done     (done),
        .error    (error),
        .error_op (error_op)
    );

    always #5 clock = ~clock;
    assign bus.rom_data = rom[bus.rom_addr];

    int n_chk = 0;
    int n_pass = 0;
    int mon_writes = 0;
    int exp_writes = 0;
    int tick_n = 0;
    int last_wr = 0;
    int probe_t = -1;
    int probe_pc = -1;

    // reference model state (instruction granularity)
    int         m_pc, m_cyc, m_size;
    logic [7:0] m_a, m_x, m_y, m_eop;
    bit         m_done, m_err;
    bit         exp_we, bnd;
    int         exp_ta, exp_td;

    always @(negedge clock)
        if (bus.tia_we === 1'b1) mon_writes++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic bit is_st(input logic [7:0] op);
        if (op == 8'h85 || op == 8'h86 || op == 8'h84) return 1'b1;
        if (op == 8'h8D || op == 8'h8E || op == 8'h8C) return ABS_EN;
        return 1'b0;
    endfunction

    function automatic int cyc_of(input logic [7:0] op);
        case (op)
            8'hA9, 8'hA2, 8'hA0, 8'hEA: return 2;
            8'h85, 8'h86, 8'h84, 8'h4C: return 3;
            8'h8D, 8'h8E, 8'h8C: return ABS_EN ? 4 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit r);
        logic [7:0] op, b1, v;
        int n, len, nxt;
        bit wr;
        exp_we = 1'b0;
        bnd = 1'b0;
        if (m_done || m_err) return;
        op = rom[AW'(m_pc)];
        n = cyc_of(op);
        wr = is_st(op) && (m_cyc == n - 1);
        if (!r && !wr) return;
        m_cyc++;
        if (n == 0) begin
            m_err = 1'b1;
            m_eop = op;
            m_pc = (m_pc + 1) % DEPTH;
            bnd = 1'b1;
            return;
        end
        if (m_cyc < n) return;
        b1 = rom[AW'((m_pc + 1) % DEPTH)];
        len = 2;
        nxt = -1;
        case (op)
            8'hA9: m_a = b1;
            8'hA2: m_x = b1;
            8'hA0: m_y = b1;
            8'hEA: len = 1;
            8'h4C: nxt = (((m_pc + 1 + 1023) / 1024) * 1024) % DEPTH;
            default: ;
        endcase
        if (is_st(op)) begin
            if (op == 8'h85 || op == 8'h8D) v = m_a;
            else if (op == 8'h86 || op == 8'h8E) v = m_x;
            else v = m_y;
            exp_we = 1'b1;
            exp_ta = int'(b1) % 64;
            exp_td = int'(v);
            exp_writes++;
            if (n == 4) len = 3;
        end
        m_pc = (nxt >= 0) ? nxt : (m_pc + len) % DEPTH;
        m_cyc = 0;
        bnd = 1'b1;
        m_done = (m_pc >= m_size);
    endtask

    task automatic tick(input bit r);
        @(negedge clock);
        cpu_tick = 1'b1;
        rdy = r;
        @(negedge clock);
        cpu_tick = 1'b0;
        tick_n++;
    endtask

    task automatic do_reset(input int sz);
        @(negedge clock);
        reset = 1'b1;
        cpu_tick = 1'b1;
        rom_size = (AW + 1)'(sz);
        @(negedge clock);
        cpu_tick = 1'b0;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_we", 32'(bus.tia_we), 0);
        chk("rst_addr", 32'(bus.rom_addr), 0);
        chk("rst_ta", 32'(bus.tia_a), 0);
        chk("rst_td", 32'(bus.tia_d), 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        m_pc = 0; m_cyc = 0; m_size = sz;
        m_a = '0; m_x = '0; m_y = '0; m_eop = '0;
        m_err = 1'b0;
        m_done = (sz == 0);
        chk("rel_done", 32'(done), 32'(m_done));
        tick_n = 0;
        last_wr = 0;
        probe_pc = -1;
    endtask

    task automatic run(input int max_t, input int pct, input int s_lo,
                       input int s_hi, input bit want_halt);
        bit r;
        int extra;
        extra = 0;
        for (int t = 1; t <= max_t; t++) begin
            r = ($urandom_range(0, 99) < pct) && !(t >= s_lo && t <= s_hi);
            tick(r);
            model_step(r);
            chk("tia_we", 32'(bus.tia_we), 32'(exp_we));
            if (bus.tia_we) last_wr = tick_n;
            if (exp_we) begin
                chk("tia_a", 32'(bus.tia_a), exp_ta);
                chk("tia_d", 32'(bus.tia_d), exp_td);
            end
            if (bnd || m_done || m_err) begin
                chk("pc", 32'(pc), m_pc);
                chk("done", 32'(done), 32'(m_done));
                chk("error", 32'(error), 32'(m_err));
                if (m_err) chk("error_op", 32'(error_op), 32'(m_eop));
            end
            if (tick_n == probe_t) probe_pc = int'(pc);
            if (m_done || m_err) extra++;
            if (extra > 3) break;
            if ($urandom_range(0, 1) == 1) begin
                rdy = 1'($urandom);
                @(negedge clock);
            end
        end
        if (want_halt) chk("halt_timeout", 32'(done | error), 1);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < DEPTH; i++) rom[AW'(i)] = v;
    endtask

    task automatic put(input int a, input logic [7:0] b);
        rom[AW'(a % DEPTH)] = b;
    endtask

    task automatic gen_rand();
        int p, k;
        logic [7:0] ops [3];
        fill(8'h02);
        p = 0;
        while (p < 1100) begin
            k = $urandom_range(0, 99);
            if (k < 3) begin
                ops = '{8'h02, 8'hFF, 8'h00};
                put(p, ops[$urandom_range(0, 2)]); p += 1;
            end else if (k < 6) begin
                put(p, 8'h4C); p += 3;
            end else if (k < 20) begin
                put(p, 8'hEA); p += 1;
            end else if (k < 50) begin
                ops = '{8'hA9, 8'hA2, 8'hA0};
                put(p, ops[$urandom_range(0, 2)]);
                put(p + 1, 8'($urandom)); p += 2;
            end else if (k < 88) begin
                ops = '{8'h85, 8'h86, 8'h84};
                put(p, ops[$urandom_range(0, 2)]);
                put(p + 1, 8'($urandom)); p += 2;
            end else begin
                ops = '{8'h8D, 8'h8E, 8'h8C};
                put(p, ops[$urandom_range(0, 2)]);
                put(p + 1, 8'($urandom));
                put(p + 2, 8'($urandom)); p += 3;
            end
        end
    endtask

    initial begin
        int w0;
        fill(8'h02);

        // LDA #1C; STA 09
        put(0, 8'hA9); put(1, 8'h1C); put(2, 8'h85); put(3, 8'h09);
        do_reset(4);
        run(20, 100, 0, -1, 1'b1);
        chk("t1_wtick", last_wr, 5);
        chk("t1_ta", 32'(bus.tia_a), 32'h09);
        chk("t1_td", 32'(bus.tia_d), 32'h1C);
        chk("t1_done", 32'(done), 1);

        // LDX #05; NOP; JMP -> 0x400; STX 07
        fill(8'h02);
        put(0, 8'hA2); put(1, 8'h05); put(2, 8'hEA); put(3, 8'h4C);
        put(4, 8'h12); put(5, 8'h34);
        put(32'h400, 8'h86); put(32'h401, 8'h07);
        do_reset(32'h402);
        probe_t = 7;
        run(30, 100, 0, -1, 1'b1);
        chk("t2_jmp_pc", probe_pc, 32'h400);
        chk("t2_wtick", last_wr, 10);
        chk("t2_td", 32'(bus.tia_d), 32'h05);

        // LDY #33 stalled by RDY, STY 02
        fill(8'h02);
        put(0, 8'hA0); put(1, 8'h33); put(2, 8'h84); put(3, 8'h02);
        do_reset(4);
        run(30, 100, 2, 4, 1'b1);
        chk("t3_wtick", last_wr, 8);
        chk("t3_td", 32'(bus.tia_d), 32'h33);

        // store write cycle ignores RDY
        fill(8'h02);
        put(0, 8'hA9); put(1, 8'h5A); put(2, 8'h85); put(3, 8'h03);
        do_reset(4);
        run(30, 100, 5, 6, 1'b1);
        chk("t4_wtick", last_wr, 5);
        chk("t4_ta", 32'(bus.tia_a), 32'h03);

        // reset between WAIT and EXEC of STA
        fill(8'h02);
        put(0, 8'hA9); put(1, 8'h11); put(2, 8'h85); put(3, 8'h05);
        do_reset(4);
        run(4, 100, 0, -1, 1'b0);
        w0 = mon_writes;
        do_reset(4);
        repeat (3) @(negedge clock);
        chk("t5_no_we", mon_writes, w0);

        // store then unknown opcode 02
        fill(8'h02);
        put(0, 8'hA9); put(1, 8'h7F); put(2, 8'h85); put(3, 8'h0D);
        put(4, 8'h02); put(5, 8'hEA);
        do_reset(8);
        run(30, 100, 0, -1, 1'b1);
        chk("t6_error", 32'(error), 1);
        chk("t6_eop", 32'(error_op), 32'h02);
        chk("t6_pc", 32'(pc), 5);
        chk("t6_wtick", last_wr, 5);

        // absolute store
        fill(8'h02);
        put(0, 8'hA9); put(1, 8'h44); put(2, 8'h8D); put(3, 8'h06);
        put(4, 8'h00);
        do_reset(5);
        run(30, 100, 0, -1, 1'b1);
`ifdef KSEQ_ABS_STORE_EN
        chk("t7_wtick", last_wr, 6);
        chk("t7_ta", 32'(bus.tia_a), 32'h06);
        chk("t7_td", 32'(bus.tia_d), 32'h44);
`else
        chk("t7_error", 32'(error), 1);
        chk("t7_eop", 32'(error_op), 32'h8D);
`endif

        // empty image
        do_reset(0);
        run(3, 100, 0, -1, 1'b1);

        // JMP chain across every bank wraps pc to 0
        fill(8'hEA);
        for (int b = 0; b < 16; b++) put(b * 1024, 8'h4C);
        do_reset(DEPTH);
        probe_t = 48;
        run(50, 100, 0, -1, 1'b0);
        chk("t9_wrap_pc", probe_pc, 0);

        for (int i = 0; i < 5; i++) begin
            gen_rand();
            do_reset($urandom_range(1, 400));
            run(3000, 75, 0, -1, 1'b1);
        end

        repeat (3) @(negedge clock);
        chk("n_writes", mon_writes, exp_writes);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
